// File: rtl/vga_pkg.sv
// Shared video-pipeline constants and the packed pixel record used between stages.
package vga_pkg;

    localparam int RECT_WIDTH  = 48;
    localparam int RECT_HEIGHT = 48;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

endpackage

// File: rtl/draw_rect_if.sv
// VGA timing/colour bundle passed between video pipeline stages.
interface vga_if;

    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
    modport out (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);

endinterface

// File: rtl/draw_rect.sv
// Overlays a ROM-textured rectangle on the VGA stream; the position is sampled once per frame
// and pixels are delayed 3 clocks to line up with the 1-clock ROM read.
module draw_rect #(
    parameter int          RECT_WIDTH  = vga_pkg::RECT_WIDTH,
    parameter int          RECT_HEIGHT = vga_pkg::RECT_HEIGHT,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [11:0] rgb_pixel,
    output logic [11:0] pixel_addr
);

    vga_pkg::vga_t vga_p0, vga_p1, vga_p2, vga_p3;

    logic [11:0] x_lat, y_lat;
    logic        pos_valid;
    logic        frame_start;
    logic [12:0] x_eff, y_eff, h13, v13;
    logic        valid_eff;
    logic        inside_p0, inside_p1, inside_p2;
    logic [5:0]  dx6, dy6;

    assign vga_p0 = {vga_in.hcount, vga_in.hsync, vga_in.hblnk,
                     vga_in.vcount, vga_in.vsync, vga_in.vblnk, vga_in.rgb};

    assign frame_start = (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);

    // On the frame-start pixel the fresh position is used directly so pixel (0,0) already sees it
    assign x_eff     = frame_start ? {1'b0, xpos} : {1'b0, x_lat};
    assign y_eff     = frame_start ? {1'b0, ypos} : {1'b0, y_lat};
    assign valid_eff = frame_start | pos_valid;
    assign h13       = {2'b00, vga_in.hcount};
    assign v13       = {2'b00, vga_in.vcount};

    // Only the low 6 bits of the offsets are needed, so subtract just those bits
    assign dx6 = vga_in.hcount[5:0] - x_eff[5:0];
    assign dy6 = vga_in.vcount[5:0] - y_eff[5:0];

    always_comb begin
        inside_p0 = valid_eff && !vga_in.hblnk && !vga_in.vblnk
                 && (h13 >= x_eff) && (h13 < x_eff + 13'(RECT_WIDTH))
                 && (v13 >= y_eff) && (v13 < y_eff + 13'(RECT_HEIGHT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_lat     <= '0;
            y_lat     <= '0;
            pos_valid <= 1'b0;
        end else if (frame_start) begin
            x_lat     <= xpos;
            y_lat     <= ypos;
            pos_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_p1     <= '0;
            inside_p1  <= 1'b0;
            pixel_addr <= '0;
            vga_p2     <= '0;
            inside_p2  <= 1'b0;
            vga_p3     <= '0;
        end else begin
            // stage 1: register input pixel, inside flag and ROM address
            vga_p1    <= vga_p0;
            inside_p1 <= inside_p0;
            if (inside_p0)
                pixel_addr <= {dy6, dx6};
            // stage 2: wait for ROM data
            vga_p2    <= vga_p1;
            inside_p2 <= inside_p1;
            // stage 3: colour-keyed overlay
            vga_p3    <= vga_p2;
            if (inside_p2 && (rgb_pixel != TRANSPARENT))
                vga_p3.rgb <= rgb_pixel;
        end
    end

    assign vga_out.hcount = vga_p3.hcount;
    assign vga_out.hsync  = vga_p3.hsync;
    assign vga_out.hblnk  = vga_p3.hblnk;
    assign vga_out.vcount = vga_p3.vcount;
    assign vga_out.vsync  = vga_p3.vsync;
    assign vga_out.vblnk  = vga_p3.vblnk;
    assign vga_out.rgb    = vga_p3.rgb;

endmodule

// File: tb/tb_draw_rect.sv
// Bench for draw_rect: directed pixel table, hand sequences and randomized pixels on 1024x768 timing.
module tb_draw_rect;

    localparam int          W      = 48;
    localparam int          H      = 48;
    localparam logic [11:0] TRANSP = 12'hF0F;
    localparam logic [11:0] BG     = 12'h00F;
    localparam logic [11:0] RED    = 12'hF00;
    localparam int          FH     = 1200;
    localparam int          FV     = 780;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } pix_t;

    typedef struct {
        bit          fs;
        int          x;
        int          y;
        int          h;
        int          v;
        logic [11:0] bg;
        int          rom;
        logic [11:0] exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos, rgb_pixel, pixel_addr;
    vga_if       vin ();
    vga_if       vout ();

    int          rom_mode;
    int          checks;
    int          errors;
    int          m_x, m_y;
    bit          m_valid;
    logic [11:0] m_addr;
    pix_t        exp_d [3];
    bit          rst_d [3];
    vec_t        tbl[$];

    draw_rect #(.RECT_WIDTH(W), .RECT_HEIGHT(H), .TRANSPARENT(TRANSP)) dut (
        .clk       (clk),
        .rst       (rst),
        .vga_in    (vin),
        .vga_out   (vout),
        .xpos      (xpos),
        .ypos      (ypos),
        .rgb_pixel (rgb_pixel),
        .pixel_addr(pixel_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(int mode, logic [11:0] a);
        case (mode)
            0:       return RED;
            1:       return (a == 12'h000) ? TRANSP : RED;
            default: return (a[3:0] == 4'h7) ? TRANSP : {a[5:0] ^ 6'h2A, a[11:6]};
        endcase
    endfunction

    // Synchronous image ROM with 1-clock read latency
    always @(posedge clk) rgb_pixel <= rom_f(rom_mode, pixel_addr);

    function automatic pix_t mk(int h, int v, logic [11:0] bg);
        pix_t p;
        p.hcount = 11'(h);
        p.hsync  = (h >= 1048 && h < 1184);
        p.hblnk  = (h >= 1024);
        p.vcount = 11'(v);
        p.vsync  = (v >= 771 && v < 777);
        p.vblnk  = (v >= 768);
        p.rgb    = bg;
        return p;
    endfunction

    function automatic pix_t cur_out();
        return {vout.hcount, vout.hsync, vout.hblnk, vout.vcount, vout.vsync, vout.vblnk, vout.rgb};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One pixel per clock; the model decides what the pixel should look like and when it emerges
    task automatic step(input int h, input int v, input logic [11:0] bg, input logic r);
        pix_t        p, e;
        logic [11:0] tex;
        p = mk(h, v, bg);
        rst = r;
        vin.hcount = p.hcount;
        vin.hsync  = p.hsync;
        vin.hblnk  = p.hblnk;
        vin.vcount = p.vcount;
        vin.vsync  = p.vsync;
        vin.vblnk  = p.vblnk;
        vin.rgb    = p.rgb;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_addr  = '0;
        end else if (h == 0 && v == 0) begin
            m_x     = int'(xpos);
            m_y     = int'(ypos);
            m_valid = 1'b1;
        end
        if (!r && m_valid && h < 1024 && v < 768 &&
            h >= m_x && h < m_x + W && v >= m_y && v < m_y + H) begin
            m_addr = 12'((v - m_y) * 64 + (h - m_x));
            tex = rom_f(rom_mode, m_addr);
            if (tex != TRANSP) p.rgb = tex;
        end
        exp_d[2] = exp_d[1]; exp_d[1] = exp_d[0]; exp_d[0] = p;
        rst_d[2] = rst_d[1]; rst_d[1] = rst_d[0]; rst_d[0] = r;
        e = (rst_d[0] || rst_d[1] || rst_d[2]) ? '0 : exp_d[2];
        #1;
        chk($sformatf("vga_out(%0d,%0d)", h, v), 64'(cur_out()), 64'(e));
        chk($sformatf("pixel_addr(%0d,%0d)", h, v), 64'(pixel_addr), 64'(m_addr));
    endtask

    task automatic chk_px(input int h, input int v, input logic [11:0] bg,
                          input logic [11:0] exp, input string name);
        step(h, v, bg, 1'b0);
        step(FH, FV, 12'h000, 1'b0);
        step(FH, FV, 12'h000, 1'b0);
        chk({name, "_rgb"}, 64'(vout.rgb), 64'(exp));
        chk({name, "_h"}, 64'(vout.hcount), 64'(h));
    endtask

    initial begin
        checks = 0; errors = 0; rom_mode = 0;
        m_x = 0; m_y = 0; m_valid = 1'b0; m_addr = '0;
        xpos = 12'd100; ypos = 12'd50;
        for (int i = 0; i < 3; i++) begin exp_d[i] = '0; rst_d[i] = 1'b1; end

        for (int i = 0; i < 3; i++) step(FH, FV, 12'h000, 1'b1);
        chk("reset_vga_out", 64'(cur_out()), 64'd0);
        chk("reset_pixel_addr", 64'(pixel_addr), 64'd0);
        step(300, 300, BG, 1'b0);
        step(100, 50, BG, 1'b0);
        step(FH, FV, 12'h000, 1'b0);
        chk("no_draw_before_latch", 64'(vout.rgb), 64'(BG));

        tbl.push_back('{1, 100,  50,  120,  60, BG,      0, RED,     "f1_inside"});
        tbl.push_back('{1, 100,  50,  100,  50, BG,      0, RED,     "top_left"});
        tbl.push_back('{0, 100,  50,  147,  50, BG,      0, RED,     "top_right"});
        tbl.push_back('{0, 100,  50,  100,  97, BG,      0, RED,     "bot_left"});
        tbl.push_back('{0, 100,  50,  147,  97, BG,      0, RED,     "bot_right"});
        tbl.push_back('{0, 100,  50,   99,  50, BG,      0, BG,      "left_out"});
        tbl.push_back('{0, 100,  50,  148,  50, BG,      0, BG,      "right_out"});
        tbl.push_back('{0, 100,  50,  120,  49, BG,      0, BG,      "top_out"});
        tbl.push_back('{0, 100,  50,  120,  98, BG,      0, BG,      "bot_out"});
        tbl.push_back('{0, 100,  50,  100,  50, BG,      1, BG,      "transparent"});
        tbl.push_back('{0, 100,  50,  101,  50, BG,      1, RED,     "transp_neighbour"});
        tbl.push_back('{1, 1000, 740, 1000, 740, BG,     0, RED,     "clip_tl"});
        tbl.push_back('{0, 1000, 740, 1023, 767, BG,     0, RED,     "clip_br"});
        tbl.push_back('{0, 1000, 740, 1024, 740, 12'h123, 0, 12'h123, "clip_hblnk"});
        tbl.push_back('{0, 1000, 740, 1047, 745, 12'h123, 0, 12'h123, "clip_hblnk2"});
        tbl.push_back('{0, 1000, 740, 1010, 768, 12'h123, 0, 12'h123, "clip_vblnk"});
        tbl.push_back('{0, 1000, 740,    5, 740, BG,     0, BG,      "no_wrap_h"});
        tbl.push_back('{0, 1000, 740,   23, 750, BG,     0, BG,      "no_wrap_h2"});
        tbl.push_back('{0, 1000, 740, 1010,   5, BG,     0, BG,      "no_wrap_v"});

        foreach (tbl[i]) begin
            rom_mode = tbl[i].rom;
            if (tbl[i].fs) begin
                xpos = 12'(tbl[i].x);
                ypos = 12'(tbl[i].y);
                step(0, 0, BG, 1'b0);
            end
            chk_px(tbl[i].h, tbl[i].v, tbl[i].bg, tbl[i].exp, tbl[i].name);
        end

        // position change coinciding with frame start applies to pixel (0,0)
        rom_mode = 0;
        xpos = 12'd0; ypos = 12'd0;
        chk_px(0, 0, BG, RED, "fs_bypass");
        chk_px(48, 0, BG, BG, "fs_bypass_edge");

        // addressing and latency
        xpos = 12'd100; ypos = 12'd50;
        step(0, 0, BG, 1'b0);
        step(105, 53, BG, 1'b0);
        chk("addr_105_53", 64'(pixel_addr), 64'h0C5);
        step(FH, FV, 12'h000, 1'b0);
        chk("latency_early", 64'(vout.hcount), 64'd0);
        step(FH, FV, 12'h000, 1'b0);
        chk("latency_h", 64'(vout.hcount), 64'd105);
        chk("latency_v", 64'(vout.vcount), 64'd53);
        chk("latency_rgb", 64'(vout.rgb), 64'(RED));

        // mid-frame move
        xpos = 12'd100; ypos = 12'd280;
        step(0, 0, BG, 1'b0);
        chk_px(100, 290, BG, RED, "move_pre");
        step(50, 300, BG, 1'b0);
        xpos = 12'd200;
        chk_px(100, 310, BG, RED, "move_old_pos");
        chk_px(200, 310, BG, BG, "move_new_pos_early");
        chk_px(147, 320, BG, RED, "move_old_edge");
        step(0, 0, BG, 1'b0);
        chk_px(200, 310, BG, RED, "move_next_frame");
        chk_px(100, 310, BG, BG, "move_old_gone");
        chk_px(247, 310, BG, RED, "move_right_edge");
        chk_px(248, 310, BG, BG, "move_right_out");

        // reset mid-frame
        xpos = 12'd100; ypos = 12'd380;
        step(0, 0, BG, 1'b0);
        chk_px(110, 390, BG, RED, "rst_pre");
        step(10, 400, BG, 1'b0);
        step(11, 400, BG, 1'b1);
        chk("rst_zero0", 64'(cur_out()), 64'd0);
        step(12, 400, BG, 1'b1);
        chk("rst_zero1", 64'(cur_out()), 64'd0);
        step(13, 400, BG, 1'b0);
        chk("rst_zero2", 64'(cur_out()), 64'd0);
        step(14, 400, BG, 1'b0);
        chk("rst_zero3", 64'(cur_out()), 64'd0);
        step(15, 400, BG, 1'b0);
        chk("rst_resume", 64'(vout.hcount), 64'd13);
        chk_px(110, 410, BG, BG, "rst_no_draw");
        step(0, 0, BG, 1'b0);
        chk_px(110, 410, BG, RED, "rst_redraw");

        // reset on the frame-start pixel wins over the latch
        step(0, 0, BG, 1'b1);
        chk_px(110, 410, BG, BG, "rst_fs_no_draw");
        step(0, 0, BG, 1'b0);
        chk_px(110, 410, BG, RED, "rst_fs_redraw");

        // randomized frames against the reference model
        rom_mode = 2;
        for (int f = 0; f < 20; f++) begin
            xpos = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(4000, 4095))
                                               : 12'($urandom_range(0, 1100));
            ypos = 12'($urandom_range(0, 800));
            step(0, 0, 12'($urandom), 1'b0);
            for (int i = 0; i < 300; i++) begin
                int   h, v;
                logic r;
                if ($urandom_range(0, 3) != 0) begin
                    h = m_x - 3 + int'($urandom_range(0, W + 6));
                    v = m_y - 3 + int'($urandom_range(0, H + 6));
                end else begin
                    h = int'($urandom_range(0, 1343));
                    v = int'($urandom_range(0, 805));
                end
                if (h < 0) h = 0;
                if (h > 1343) h = 1343;
                if (v < 0) v = 0;
                if (v > 805) v = 805;
                if ($urandom_range(0, 15) == 0) xpos = 12'($urandom);
                if ($urandom_range(0, 15) == 0) ypos = 12'($urandom);
                r = ($urandom_range(0, 99) == 0);
                step(h, v, 12'($urandom), r);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/draw_rect.md
# draw_rect

Overlays a textured rectangle on the VGA timing stream at the position produced by the rectangle position controller. Sits directly downstream of that controller in the video pipeline, between the background stage and the final RGB output. It reads `xpos` and `ypos` once per frame, generates image-ROM addresses, and substitutes ROM pixels for background pixels inside the rectangle. Transparent texels pass the background through unchanged.

## Interface
Parameters:
- `RECT_WIDTH`, default `vga_pkg::RECT_WIDTH`. Rectangle width in pixels, 1..64.
- `RECT_HEIGHT`, default `vga_pkg::RECT_HEIGHT`. Rectangle height in pixels, 1..64.
- `TRANSPARENT`, default `12'hF0F`. ROM colour key that shows the background.

Ports:
- `clk`  in  1  Pixel clock. The block uses one clock domain.
- `rst`  in  1  Reset, synchronous and active-high.
- `vga_in`  `vga_if.in`  —  Input timing and colour: `hcount[10:0]`, `hsync`, `hblnk`, `vcount[10:0]`, `vsync`, `vblnk`, `rgb[11:0]`.
- `vga_out`  `vga_if.out`  —  The same fields, delayed 3 clocks, with `rgb` overlaid.
- `xpos`  in  12  Rectangle left edge, from the position controller.
- `ypos`  in  12  Rectangle top edge, from the position controller.
- `rgb_pixel`  in  12  Image ROM data. Valid 1 clock after `pixel_addr`.
- `pixel_addr`  out  12  Image ROM address, `{row[5:0], col[5:0]}`.

## Operation
- **Position latch:**
  - The block holds `x_lat`, `y_lat` and `pos_valid`.
  - On any cycle with `vga_in.hcount==0 && vga_in.vcount==0`, it loads `x_lat<=xpos`, `y_lat<=ypos` and `pos_valid<=1`.
  - The rectangle therefore never tears mid-frame.
- **Inside test (stage 1):**
  - All arithmetic is 13-bit zero-extended, so `x_lat+RECT_WIDTH` never wraps.
  - `inside = pos_valid && !hblnk && !vblnk && hcount>=x_lat && hcount<x_lat+RECT_WIDTH && vcount>=y_lat && vcount<y_lat+RECT_HEIGHT`.
- **Address (stage 1):**
  - `dx=hcount-x_lat`, `dy=vcount-y_lat`, both truncated to 6 bits.
  - `pixel_addr<={dy[5:0],dx[5:0]}` when `inside`. It holds its previous value otherwise.
- **Pipeline:**
  - Stage 1 registers a copy of `vga_in`, `inside` and `pixel_addr`.
  - Stage 2 registers a delayed copy of the stage-1 VGA fields and `inside`. `rgb_pixel` arrives aligned with stage 2.
  - Stage 3 registers `vga_out`. `vga_out.rgb = (inside_s2 && rgb_pixel!=TRANSPARENT) ? rgb_pixel : rgb_s2`. All other fields pass unchanged.
- **Clipping:** Rectangle parts extending past the visible area are suppressed by the blanking terms. There is no wrap to the left or top edge.
- **Reset:**
  - All stage registers, `vga_out` (every field), `pixel_addr`, `x_lat`, `y_lat` and `pos_valid` clear to 0.
  - After reset, nothing is drawn until the next frame-start latch, even if reset is released mid-frame.

## Timing
- Latency from `vga_in` to `vga_out` is exactly 3 clocks for every field.
- `pixel_addr` is valid 1 clock after the input pixel. The ROM has a fixed 1-clock read latency with no handshake.
- `xpos`/`ypos` changes outside the frame-start cycle have no effect until the next `hcount==0 && vcount==0`.
- When a position change and the frame-start cycle coincide, the new value is latched and takes effect on that same frame's pixel (0,0).
- When reset and the frame-start cycle coincide, reset wins and `pos_valid` stays 0.
- Boundary pixels:
  - `hcount==x_lat` is inside.
  - `hcount==x_lat+RECT_WIDTH` is outside.
  - The same rule applies to rows.

## Test plan
- **Basic overlay.** Background rgb=12'h00F, `xpos=100`, `ypos=50`, `RECT_WIDTH=RECT_HEIGHT=48`, ROM returns 12'hF00 everywhere, run 2 frames. Required response:
  - In frame 2, output pixels (100..147, 50..97) are 12'hF00.
  - Pixels (99,50) and (148,50) are 12'h00F.
- **Addressing.** Same setup. At input pixel (105,53), `pixel_addr` is 12'h0C5 one clock later (row 3, col 5). `vga_out` for that pixel appears 3 clocks after input.
- **Transparency.** ROM returns 12'hF0F at address 12'h000. Output pixel (100,50) equals the background 12'h00F, while its neighbour (101,50) shows ROM data.
- **Mid-frame move.** Change `xpos` 100→200 at vcount=300. Required response:
  - The rest of the frame is still drawn at x=100.
  - The next frame is drawn at x=200.
- **Right/bottom clip.** `xpos=1000`, `ypos=740` on 1024x768 timing. Required response:
  - Only visible pixels (1000..1023, 740..767) are overlaid.
  - No overlay appears at hcount 0..23, and all blanking rgb is unchanged.
- **Reset mid-frame.** Assert `rst` for 2 clocks at vcount=400. Required response:
  - `vga_out` is all zero, starting 1 clock after the first reset clock edge and until 3 clocks after release.
  - No rectangle is drawn for the rest of the frame.
  - The rectangle reappears in the next frame.
